// File: rtl/dly_tap_pkg.sv
// Shared types and constants for the delay-tap control array.
package dly_tap_pkg;

  localparam int DLY_TAP_W   = 6;
  localparam int DLY_NUM_CH  = 20;
  localparam int DLY_TAP_MAX = (1 << DLY_TAP_W) - 1;

  typedef enum logic [1:0] {
    NOP  = 2'b00,
    LOAD = 2'b01,
    INC  = 2'b10,
    DEC  = 2'b11
  } dly_op_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    APPLY  = 2'd1,
    SETTLE = 2'd2
  } dly_state_e;

endpackage

// File: rtl/dly_tap_alu.sv
// Next-tap computation for one channel: load, saturating inc/dec.
// Build with DLY_TAP_WRAP_EN defined to make inc/dec wrap modulo 2^TAP_W.
import dly_tap_pkg::*;

module dly_tap_alu #(
  parameter int TAP_W = DLY_TAP_W
) (
  input  dly_op_e          op,
  input  logic [TAP_W-1:0] cur,
  input  logic [TAP_W-1:0] data,
  output logic [TAP_W-1:0] nxt
);

  logic [TAP_W:0]   inc_w;
  logic [TAP_W:0]   dec_w;
  logic [TAP_W-1:0] inc_v;
  logic [TAP_W-1:0] dec_v;

  // One extra bit catches the carry out of the top and the borrow below zero.
  assign inc_w = {1'b0, cur} + {{TAP_W{1'b0}}, 1'b1};
  assign dec_w = {1'b0, cur} - {{TAP_W{1'b0}}, 1'b1};

`ifdef DLY_TAP_WRAP_EN
  // Dropping the extra bit gives modulo arithmetic.
  assign inc_v = inc_w[TAP_W-1:0];
  assign dec_v = dec_w[TAP_W-1:0];
`else
  // Carry means we were at max, borrow means we were at zero: hold there.
  assign inc_v = inc_w[TAP_W] ? {TAP_W{1'b1}} : inc_w[TAP_W-1:0];
  assign dec_v = dec_w[TAP_W] ? {TAP_W{1'b0}} : dec_w[TAP_W-1:0];
`endif

  // Select the result for the requested operation.
  always_comb begin
    nxt = cur;
    case (op)
      LOAD:    nxt = data;
      INC:     nxt = inc_v;
      DEC:     nxt = dec_v;
      default: nxt = cur;
    endcase
  end

endmodule

// File: rtl/dly_tap_ctrl_array.sv
// Delay-tap control array: holds NUM_DLY tap registers, applies one
// addressed load/inc/dec per command, then stays busy SETTLE_CYCLES cycles.
// Optional macro DLY_TAP_WRAP_EN (handled in dly_tap_alu) selects wrapping
// instead of saturating inc/dec.
import dly_tap_pkg::*;

module dly_tap_ctrl_array #(
  parameter int               NUM_DLY       = DLY_NUM_CH,
  parameter int               TAP_W         = DLY_TAP_W,
  parameter int               SETTLE_CYCLES = 4,
  parameter logic [TAP_W-1:0] INIT_TAP      = '0
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             CMD_VALID,
  output logic             CMD_READY,
  input  logic [1:0]       CMD_OP,
  input  logic [4:0]       CMD_ADDR,
  input  logic [TAP_W-1:0] CMD_DATA,
  output logic [TAP_W-1:0] DLY_TAP_VAL_ARRAY [NUM_DLY-1:0],
  output logic             UPD_DONE,
  output logic             CMD_ERR,
  output logic             BUSY
);

  localparam logic [5:0] NUM_DLY_V = 6'(NUM_DLY);
  localparam logic [7:0] SETTLE_LD = 8'(SETTLE_CYCLES - 1);
  localparam bit         NO_SETTLE = (SETTLE_CYCLES == 0);

  dly_state_e       state;
  dly_op_e          op_q;
  logic [4:0]       addr_q;
  logic [TAP_W-1:0] data_q;
  logic [7:0]       cnt;
  logic             addr_err;
  logic [TAP_W-1:0] cur_tap;
  logic [TAP_W-1:0] nxt_tap;

  // Compare in 6 bits so NUM_DLY = 32 leaves every 5-bit address legal.
  assign addr_err  = ({1'b0, addr_q} >= NUM_DLY_V);
  assign CMD_READY = (state == IDLE);
  assign BUSY      = (state != IDLE);
  assign CMD_ERR   = (state == APPLY) && addr_err;
  assign UPD_DONE  = ((state == APPLY) && NO_SETTLE) ||
                     ((state == SETTLE) && (cnt == 8'd0));

  // Read back the addressed channel; out-of-range addresses never write.
  always_comb begin
    cur_tap = INIT_TAP;
    for (int i = 0; i < NUM_DLY; i++)
      if (addr_q == 5'(i)) cur_tap = DLY_TAP_VAL_ARRAY[i];
  end

  dly_tap_alu #(.TAP_W(TAP_W)) u_alu (
    .op   (op_q),
    .cur  (cur_tap),
    .data (data_q),
    .nxt  (nxt_tap)
  );

  // Command FSM: latch on handshake, one APPLY cycle, then settle countdown.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state  <= IDLE;
      op_q   <= NOP;
      addr_q <= '0;
      data_q <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: if (CMD_VALID) begin
          op_q   <= dly_op_e'(CMD_OP);
          addr_q <= CMD_ADDR;
          data_q <= CMD_DATA;
          state  <= APPLY;
        end
        APPLY: if (NO_SETTLE) state <= IDLE;
               else begin
                 state <= SETTLE;
                 cnt   <= SETTLE_LD;
               end
        SETTLE: if (cnt == 8'd0) state <= IDLE;
                else             cnt   <= cnt - 8'd1;
        default: state <= IDLE;
      endcase
    end
  end

  // Tap registers: only the addressed channel updates, and only in APPLY.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < NUM_DLY; i++) DLY_TAP_VAL_ARRAY[i] <= INIT_TAP;
    end else if ((state == APPLY) && !addr_err) begin
      for (int i = 0; i < NUM_DLY; i++)
        if (addr_q == 5'(i)) DLY_TAP_VAL_ARRAY[i] <= nxt_tap;
    end
  end

endmodule

// File: tb/tb_dly_tap_ctrl_array.sv
// Bench for dly_tap_ctrl_array: vector table through a scoreboard, plus
// hand-written reset-abort and zero-settle sequences.
import dly_tap_pkg::*;

module tb_dly_tap_ctrl_array;

  localparam int NUM_DLY = 20;
  localparam int TAP_W   = 6;
  localparam int SETTLE  = 4;
  localparam int NVEC    = 16;

`ifdef DLY_TAP_WRAP_EN
  localparam logic [5:0] INC_TOP = 6'd0;
  localparam logic [5:0] DEC_BOT = 6'd63;
`else
  localparam logic [5:0] INC_TOP = 6'd63;
  localparam logic [5:0] DEC_BOT = 6'd0;
`endif

  typedef struct {
    logic [1:0] op;
    logic [4:0] addr;
    logic [5:0] data;
    logic [5:0] exp;
    bit         err;
  } vec_t;

  typedef struct {
    int addr;
    int exp;
    bit err;
    int hs_cyc;
  } sb_t;

  logic             CLK = 1'b0;
  logic             RESET;
  logic             CMD_VALID, CMD_READY, UPD_DONE, CMD_ERR, BUSY;
  logic [1:0]       CMD_OP;
  logic [4:0]       CMD_ADDR;
  logic [TAP_W-1:0] CMD_DATA;
  logic [TAP_W-1:0] tap_arr [NUM_DLY-1:0];

  logic             z_valid, z_ready, z_done, z_err, z_busy;
  logic [1:0]       z_op;
  logic [4:0]       z_addr;
  logic [TAP_W-1:0] z_data;
  logic [TAP_W-1:0] z_arr [NUM_DLY-1:0];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int done_cnt = 0;
  sb_t sb[$];
  logic [5:0] mdl [NUM_DLY];
  vec_t vt [NVEC];
  bit  pend_vis = 0;
  int  vis_cyc, vis_addr, vis_exp;
  bit  err_seen = 0;
  int  err_cyc  = 0;
  int  prev_hs  = 0;

  dly_tap_ctrl_array #(.NUM_DLY(NUM_DLY), .TAP_W(TAP_W), .SETTLE_CYCLES(SETTLE)) dut (
    .CLK(CLK), .RESET(RESET), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
    .CMD_OP(CMD_OP), .CMD_ADDR(CMD_ADDR), .CMD_DATA(CMD_DATA),
    .DLY_TAP_VAL_ARRAY(tap_arr), .UPD_DONE(UPD_DONE), .CMD_ERR(CMD_ERR), .BUSY(BUSY)
  );

  dly_tap_ctrl_array #(.NUM_DLY(NUM_DLY), .TAP_W(TAP_W), .SETTLE_CYCLES(0)) dut_z (
    .CLK(CLK), .RESET(RESET), .CMD_VALID(z_valid), .CMD_READY(z_ready),
    .CMD_OP(z_op), .CMD_ADDR(z_addr), .CMD_DATA(z_data),
    .DLY_TAP_VAL_ARRAY(z_arr), .UPD_DONE(z_done), .CMD_ERR(z_err), .BUSY(z_busy)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int mism_cnt();
    int m = 0;
    for (int i = 0; i < NUM_DLY; i++) if (tap_arr[i] !== mdl[i]) m++;
    return m;
  endfunction

  // Drive one command with CMD_VALID held until the handshake edge.
  task automatic send(input logic [1:0] op, input logic [4:0] addr, input logic [5:0] data,
                      input logic [5:0] exp, input bit err, input bit chk_gap);
    int  n = 0;
    sb_t e;
    @(negedge CLK);
    CMD_VALID = 1'b1; CMD_OP = op; CMD_ADDR = addr; CMD_DATA = data;
    while (!CMD_READY && n < 100) begin
      @(negedge CLK);
      n++;
    end
    if (!CMD_READY) begin
      chk("handshake_timeout", 0, 1);
      CMD_VALID = 1'b0;
      return;
    end
    @(posedge CLK);
    #1;
    if (chk_gap) chk("hs_spacing", cyc - prev_hs, SETTLE + 2);
    prev_hs = cyc;
    e.addr = addr; e.exp = exp; e.err = err; e.hs_cyc = cyc;
    sb.push_back(e);
    if (!err) begin
      mdl[addr] = exp;
      pend_vis = 1; vis_cyc = cyc + 1; vis_addr = addr; vis_exp = exp;
    end
  endtask

  task automatic drain();
    int n = 0;
    @(negedge CLK);
    CMD_VALID = 1'b0;
    while (sb.size() > 0 && n < 100) begin
      @(negedge CLK);
      n++;
    end
    chk("drain_left", sb.size(), 0);
  endtask

  // Output monitor: sampled on the falling edge, pops the scoreboard on UPD_DONE.
  initial begin
    sb_t e;
    forever begin
      @(negedge CLK);
      if (!RESET) begin
        chk("ready_vs_busy", CMD_READY, !BUSY);
        if (CMD_ERR) begin
          err_seen = 1;
          err_cyc  = cyc;
        end
        if (pend_vis && cyc == vis_cyc) begin
          chk("tap_visible", tap_arr[vis_addr], vis_exp);
          pend_vis = 0;
        end
        if (UPD_DONE) begin
          if (sb.size() == 0) chk("spurious_done", 1, 0);
          else begin
            e = sb.pop_front();
            done_cnt++;
            chk("done_latency", cyc - e.hs_cyc, SETTLE);
            chk("err_pulse", err_seen, e.err);
            if (e.err) chk("err_in_apply", err_cyc - e.hs_cyc, 0);
            chk("array_vs_model", mism_cnt(), 0);
            err_seen = 0;
          end
        end
      end
    end
  end

  initial begin
    int d0, h0, h1;
    RESET = 1'b1; CMD_VALID = 1'b0; CMD_OP = '0; CMD_ADDR = '0; CMD_DATA = '0;
    z_valid = 1'b0; z_op = '0; z_addr = '0; z_data = '0;
    for (int i = 0; i < NUM_DLY; i++) mdl[i] = 6'd0;

    vt[0]  = '{LOAD, 5'd5,  6'd42, 6'd42,   1'b0};
    vt[1]  = '{LOAD, 5'd0,  6'd63, 6'd63,   1'b0};
    vt[2]  = '{INC,  5'd0,  6'd0,  INC_TOP, 1'b0};
    vt[3]  = '{DEC,  5'd1,  6'd0,  DEC_BOT, 1'b0};
    vt[4]  = '{LOAD, 5'd20, 6'd7,  6'd0,    1'b1};
    vt[5]  = '{NOP,  5'd5,  6'd11, 6'd42,   1'b0};
    vt[6]  = '{DEC,  5'd5,  6'd0,  6'd41,   1'b0};
    vt[7]  = '{INC,  5'd5,  6'd0,  6'd42,   1'b0};
    vt[8]  = '{LOAD, 5'd4,  6'd62, 6'd62,   1'b0};
    vt[9]  = '{INC,  5'd4,  6'd0,  6'd63,   1'b0};
    vt[10] = '{LOAD, 5'd3,  6'd1,  6'd1,    1'b0};
    vt[11] = '{DEC,  5'd3,  6'd0,  6'd0,    1'b0};
    vt[12] = '{INC,  5'd31, 6'd0,  6'd0,    1'b1};
    vt[13] = '{INC,  5'd19, 6'd0,  6'd1,    1'b0};
    vt[14] = '{INC,  5'd19, 6'd0,  6'd2,    1'b0};
    vt[15] = '{INC,  5'd19, 6'd0,  6'd3,    1'b0};

    repeat (3) @(negedge CLK);
    chk("rst_ready", CMD_READY, 1);
    chk("rst_busy",  BUSY, 0);
    chk("rst_done",  UPD_DONE, 0);
    chk("rst_err",   CMD_ERR, 0);
    chk("rst_array", mism_cnt(), 0);
    RESET = 1'b0;

    // Whole table back to back with CMD_VALID held between commands.
    for (int i = 0; i < NVEC; i++)
      send(vt[i].op, vt[i].addr, vt[i].data, vt[i].exp, vt[i].err, i > 0);
    drain();
    chk("ch19_after_3inc", tap_arr[19], 3);
    chk("done_count", done_cnt, NVEC);

    // Reset in SETTLE discards the command and suppresses UPD_DONE.
    send(LOAD, 5'd7, 6'd10, 6'd10, 1'b0, 1'b0);
    @(negedge CLK);
    CMD_VALID = 1'b0;
    @(negedge CLK);
    #2;
    RESET = 1'b1;
    sb.delete(); pend_vis = 0; err_seen = 0;
    for (int i = 0; i < NUM_DLY; i++) mdl[i] = 6'd0;
    #1;
    chk("abort_tap7", tap_arr[7], 0);
    chk("abort_busy", BUSY, 0);
    chk("abort_ready", CMD_READY, 1);
    chk("abort_array", mism_cnt(), 0);
    d0 = done_cnt;
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    repeat (8) @(negedge CLK);
    chk("no_done_after_abort", done_cnt - d0, 0);

    // Zero-settle instance: done in APPLY, next accept one cycle later.
    @(negedge CLK);
    z_valid = 1'b1; z_op = LOAD; z_addr = 5'd2; z_data = 6'd9;
    chk("z_ready_idle", z_ready, 1);
    @(posedge CLK);
    #1;
    h0 = cyc;
    @(negedge CLK);
    chk("z_done_apply", z_done, 1);
    chk("z_ready_apply", z_ready, 0);
    chk("z_err_apply", z_err, 0);
    z_op = INC;
    @(negedge CLK);
    chk("z_tap2_load", z_arr[2], 9);
    chk("z_ready_back", z_ready, 1);
    chk("z_done_idle", z_done, 0);
    @(posedge CLK);
    #1;
    h1 = cyc;
    chk("z_hs_gap", h1 - h0, 2);
    @(negedge CLK);
    z_valid = 1'b0;
    chk("z_done_2nd", z_done, 1);
    @(negedge CLK);
    chk("z_tap2_inc", z_arr[2], 10);
    chk("z_tap3_untouched", z_arr[3], 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dly_tap_ctrl_array.md
Name: dly_tap_ctrl_array

Overview:
- Upstream stage of the delay-tap value multiplexer. Holds the 20 per-channel 6-bit delay tap values and drives them as the 20-entry tap array that the mux selects from.
- Accepts addressed load, increment and decrement commands over a valid/ready handshake.
- Applies each command to one channel with saturation, then holds off new commands for a programmable settle period so the analog delay line can track.

Parameters:
- NUM_DLY, 20, number of delay channels; legal range 1..32.
- TAP_W, 6, tap value width; max tap = 2^TAP_W-1 = 63.
- SETTLE_CYCLES, 4, busy cycles after each applied update; legal range 0..255.
- INIT_TAP, 0, reset value of every channel tap.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RESET  input  1  asynchronous, active-high reset.
- CMD_VALID  input  1  command present.
- CMD_READY  output  1  command accepted this cycle when CMD_VALID && CMD_READY.
- CMD_OP  input  2  00 = NOP, 01 = LOAD, 10 = INC, 11 = DEC.
- CMD_ADDR  input  5  target channel.
- CMD_DATA  input  TAP_W  load value; ignored for INC, DEC and NOP.
- DLY_TAP_VAL_ARRAY  output  TAP_W x NUM_DLY  registered tap value per channel (unpacked array [NUM_DLY-1:0]).
- UPD_DONE  output  1  one-cycle pulse when a command completes (returns to IDLE).
- CMD_ERR  output  1  one-cycle pulse when an accepted command has CMD_ADDR >= NUM_DLY.
- BUSY  output  1  high in every state except IDLE.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset state:
  - All DLY_TAP_VAL_ARRAY entries = INIT_TAP.
  - FSM = IDLE.
  - CMD_READY = 1, BUSY = 0, UPD_DONE = 0, CMD_ERR = 0.
- FSM states: IDLE, APPLY, SETTLE.
- IDLE:
  - CMD_READY = 1.
  - On handshake: latch op, address and data; go to APPLY.
  - CMD_VALID low: stay in IDLE.
- APPLY (exactly 1 cycle, CMD_READY = 0):
  - Update the latched channel register:
    - LOAD: tap = CMD_DATA.
    - INC: tap = min(tap+1, 63).
    - DEC: tap = max(tap-1, 0).
    - NOP: no change.
  - Arithmetic uses TAP_W+1 bits internally, then clamps. An INC at 63 or a DEC at 0 leaves the value unchanged.
  - Address >= NUM_DLY: no register changes; CMD_ERR pulses this cycle.
  - Next state: SETTLE if SETTLE_CYCLES > 0, else IDLE with UPD_DONE pulsed.
- SETTLE:
  - 8-bit down-counter loaded with SETTLE_CYCLES-1 on entry from APPLY.
  - Decrements each cycle; at 0 go to IDLE and pulse UPD_DONE on that transition cycle.
  - CMD_READY = 0 throughout.
- Latency:
  - Handshake at edge N: array value visible after edge N+1.
  - UPD_DONE high in cycle N+1+SETTLE_CYCLES (N+1 if SETTLE_CYCLES = 0).
  - Next command accepted at the earliest one cycle after UPD_DONE (CMD_READY re-asserts in IDLE).
- Protocol rules:
  - CMD_VALID held while busy is not consumed; the bench holds it until the handshake.
  - Only one channel changes per command; other channels are always stable.
- Reset asserted mid-operation: immediate return to reset state. The in-flight command is discarded and no UPD_DONE is issued.
- NOP and error commands still take the full APPLY+SETTLE time.

Optional Feature:
- Macro: DLY_TAP_WRAP_EN.
- Defined: INC at 63 wraps to 0, DEC at 0 wraps to 63 (modulo 2^TAP_W).
- Undefined (default): saturating behaviour as specified above.
- LOAD, timing and all handshakes are identical in both builds.

Decomposition:
- Package dly_tap_pkg:
  - Typedef dly_op_e: NOP, LOAD, INC, DEC.
  - Typedef dly_state_e: IDLE, APPLY, SETTLE.
  - Constants DLY_TAP_W = 6, DLY_NUM_CH = 20, DLY_TAP_MAX = 63.
- Sub-module dly_tap_alu: combinational next-tap computation (op, current tap, data -> next tap), including the saturate/wrap macro. Instantiated once in the top-level.
- FSM, settle counter and register array stay in the top-level.

Test Plan:
- Reset, then LOAD addr 5 data 42, SETTLE_CYCLES = 4 -> array[5] = 42 one edge after the handshake; UPD_DONE pulse 5 cycles after the handshake; all other entries remain 0.
- LOAD addr 0 = 63, then INC addr 0 -> stays 63 (saturate build); becomes 0 with DLY_TAP_WRAP_EN. DEC addr 1 at 0 -> stays 0 (saturate build); becomes 63 with DLY_TAP_WRAP_EN.
- Command with addr 20 -> CMD_ERR pulses in APPLY; no array entry changes; UPD_DONE still pulses.
- Back-to-back CMD_VALID held high with 3 INCs to addr 19 -> CMD_READY low during APPLY/SETTLE; exactly 3 handshakes; array[19] = 3.
- RESET asserted during SETTLE after LOAD addr 7 = 10 -> array[7] returns to INIT_TAP asynchronously; BUSY = 0; no UPD_DONE.
- SETTLE_CYCLES = 0 build: LOAD addr 2 = 9 -> UPD_DONE in the cycle after the handshake; next command accepted the following cycle.
